pb_debounce_array: RTL and testbench
====================================

PB_DEBOUNCE_ARRAY -- requirements
Module: pb_debounce_array

Interface
REQ-001 The block SHALL expose parameter N_CH, default 4: number of independent push-button channels (1..32).
REQ-002 The block SHALL expose parameter CNT_W, default 20: width of every per-channel counter.
REQ-003 The block SHALL expose parameter STABLE_CNT, default 100000: consecutive sampled cycles of a new level required before the debounced level changes (1..2^CNT_W-1).
REQ-004 The block SHALL expose parameter LONG_CNT, default 1000000: cycles of debounced-high before the long-press pulse (2..2^CNT_W-1).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 pb_in  input  N_CH  raw asynchronous push-button levels, bit i = channel i.
REQ-008 pb_debounced  output  N_CH  registered debounced level per channel.
REQ-009 pb_press  output  N_CH  one-cycle pulse on debounced 0->1.
REQ-010 pb_release  output  N_CH  one-cycle pulse on debounced 1->0.
REQ-011 pb_long  output  N_CH  one-cycle pulse when a press has been held LONG_CNT cycles.

Function
REQ-012 Each pb_in bit SHALL pass through a 2-flop synchronizer; only the second flop (sync) feeds the debounce logic.
REQ-013 Per channel, when sync != pb_debounced the stable counter SHALL increment by 1 per edge; when sync == pb_debounced it SHALL clear to 0 on that edge.
REQ-014 When sync != pb_debounced and stable counter == STABLE_CNT-1, pb_debounced SHALL toggle on that edge and the counter SHALL clear to 0.
REQ-015 Latency: a clean pb_in edge sampled first at edge 1 SHALL change pb_debounced at edge 2+STABLE_CNT.
REQ-016 Any excursion of sync shorter than STABLE_CNT cycles SHALL leave pb_debounced unchanged and the counter restarted from 0.
REQ-017 pb_press SHALL be high exactly in the cycle following the edge where pb_debounced goes 0->1 (registered in the same edge); pb_release likewise for 1->0; never both in one cycle per channel.
REQ-018 Per channel, a hold counter SHALL clear when pb_debounced is 0 and increment each edge while pb_debounced is 1, saturating at LONG_CNT.
REQ-019 pb_long SHALL pulse for exactly one cycle, registered on the edge at which the hold counter goes LONG_CNT-1 -> LONG_CNT, i.e. LONG_CNT edges after the press edge; at most once per press.
REQ-020 Release before LONG_CNT SHALL produce no pb_long; hold counter clears on the release edge.
REQ-021 Channels SHALL be fully independent; simultaneous events on all channels SHALL each be handled per REQ-013..020 in the same cycle.
REQ-022 Counters SHALL never wrap; all compares are unsigned CNT_W-bit.

Reset
REQ-023 While rst_n is 0, synchronizer flops, all counters, pb_debounced, pb_press, pb_release and pb_long SHALL be 0, asynchronously.
REQ-024 Reset asserted mid-debounce or mid-hold SHALL discard progress; after deassertion a held button SHALL require the full 2+STABLE_CNT edges and then pb_press.
REQ-025 The first edge after deassertion SHALL produce no pulses unless REQ-014 is met.

Verification (N_CH=4, STABLE_CNT=4, LONG_CNT=10)
REQ-026 pb_in[0] 0->1 held -> pb_debounced[0]=1 and pb_press[0]=1 after edge 6, pb_press[0]=0 after edge 7; other channels stay 0.
REQ-027 pb_in[1] high for 3 cycles then low -> pb_debounced[1], pb_press[1] remain 0 throughout.
REQ-028 pb_in[2] bouncing 1,0,1,1,1,1 -> pb_debounced[2] rises 4 stable sampled cycles after the last 0, one pb_press[2].
REQ-029 pb_in[3] held 20 cycles past press -> single pb_long[3] 10 edges after pb_press[3]; release -> pb_release[3] at edge 2+4 after the drop, no second pb_long.
REQ-030 pb_in=4'b1111 simultaneously, rst_n pulsed low at edge 4 -> all outputs 0 immediately; pb_press=4'b1111 exactly 6 edges after deassertion.

Source files
------------

// File: rtl/pb_debounce_array.sv
// rtl/pb_debounce_array.sv - per-channel push-button synchronizer, debouncer and press/release/long-press detector
module pb_debounce_array #(
    parameter int N_CH       = 4,
    parameter int CNT_W      = 20,
    parameter int STABLE_CNT = 100000,
    parameter int LONG_CNT   = 1000000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] pb_in,
    output logic [N_CH-1:0] pb_debounced,
    output logic [N_CH-1:0] pb_press,
    output logic [N_CH-1:0] pb_release,
    output logic [N_CH-1:0] pb_long
);

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CNT - 1);
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CNT - 1);
    localparam logic [CNT_W-1:0] LONG_MAX    = CNT_W'(LONG_CNT);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic [N_CH-1:0]  sync1_q, sync1_d;
    logic [N_CH-1:0]  sync2_q, sync2_d;
    logic [N_CH-1:0]  deb_q, deb_d;
    logic [N_CH-1:0]  press_q, press_d;
    logic [N_CH-1:0]  release_q, release_d;
    logic [N_CH-1:0]  long_q, long_d;
    logic [CNT_W-1:0] stable_q [N_CH];
    logic [CNT_W-1:0] stable_d [N_CH];
    logic [CNT_W-1:0] hold_q   [N_CH];
    logic [CNT_W-1:0] hold_d   [N_CH];

    always_comb begin
        sync1_d = pb_in;
        sync2_d = sync1_q;
        deb_d   = deb_q;
        long_d  = '0;
        for (int ch = 0; ch < N_CH; ch++) begin
            stable_d[ch] = '0;
            hold_d[ch]   = '0;
            if (sync2_q[ch] != deb_q[ch]) begin
                if (stable_q[ch] == STABLE_LAST) begin
                    deb_d[ch] = ~deb_q[ch];
                end else begin
                    stable_d[ch] = stable_q[ch] + CNT_ONE;
                end
            end
            // Hold time counts only while the level was and stays high, so it
            // starts at 0 on the press edge and clears on the release edge.
            if (deb_q[ch] && deb_d[ch]) begin
                hold_d[ch] = (hold_q[ch] == LONG_MAX) ? hold_q[ch] : hold_q[ch] + CNT_ONE;
                long_d[ch] = (hold_q[ch] == LONG_LAST);
            end
        end
        press_d   = deb_d & ~deb_q;
        release_d = ~deb_d & deb_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            deb_q     <= '0;
            press_q   <= '0;
            release_q <= '0;
            long_q    <= '0;
            for (int ch = 0; ch < N_CH; ch++) begin
                stable_q[ch] <= '0;
                hold_q[ch]   <= '0;
            end
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            deb_q     <= deb_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            for (int ch = 0; ch < N_CH; ch++) begin
                stable_q[ch] <= stable_d[ch];
                hold_q[ch]   <= hold_d[ch];
            end
        end
    end

    assign pb_debounced = deb_q;
    assign pb_press     = press_q;
    assign pb_release   = release_q;
    assign pb_long      = long_q;

endmodule

// File: tb/tb_pb_debounce_array.sv
// tb/tb_pb_debounce_array.sv - randomized scoreboard bench for pb_debounce_array
module tb_pb_debounce_array;

    localparam int N  = 4;
    localparam int S  = 4;
    localparam int L  = 10;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] pb_in;
    logic [N-1:0] pb_debounced, pb_press, pb_release, pb_long;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [4*N-1:0] exp_q [$];

    // Reference model: window of the last S synchronized samples.
    logic [N-1:0] m_p1, m_p2, m_deb;
    logic [N-1:0] m_win [$];
    bit           m_held [N];
    int           m_press_t [N];
    int           m_t;

    pb_debounce_array #(.N_CH(N), .CNT_W(8), .STABLE_CNT(S), .LONG_CNT(L)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pb_in        (pb_in),
        .pb_debounced (pb_debounced),
        .pb_press     (pb_press),
        .pb_release   (pb_release),
        .pb_long      (pb_long)
    );

    always #5 clk = ~clk;

    task automatic model_edge(input logic [N-1:0] pin, input logic rn);
        logic [N-1:0] nd, pr, rl, lg;
        bit all_diff;
        if (!rn) begin
            m_p1 = '0; m_p2 = '0; m_deb = '0;
            m_win.delete();
            for (int c = 0; c < N; c++) m_held[c] = 0;
            exp_q.push_back('0);
            return;
        end
        m_win.push_back(m_p2);
        if (m_win.size() > S) void'(m_win.pop_front());
        nd = m_deb; lg = '0;
        for (int c = 0; c < N; c++) begin
            all_diff = (m_win.size() == S);
            foreach (m_win[j]) if (m_win[j][c] == m_deb[c]) all_diff = 0;
            if (all_diff) nd[c] = ~m_deb[c];
        end
        pr = nd & ~m_deb;
        rl = ~nd & m_deb;
        for (int c = 0; c < N; c++) begin
            if (pr[c]) begin m_held[c] = 1; m_press_t[c] = m_t; end
            if (rl[c]) m_held[c] = 0;
            if (m_held[c] && nd[c] && (m_t == m_press_t[c] + L)) lg[c] = 1'b1;
        end
        m_p2 = m_p1; m_p1 = pin; m_deb = nd; m_t++;
        exp_q.push_back({nd, pr, rl, lg});
    endtask

    task automatic step(input logic [N-1:0] pin, input logic rn);
        @(negedge clk);
        pb_in = pin;
        rst_n = rn;
        model_edge(pin, rn);
    endtask

    initial begin : monitor
        logic [4*N-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({pb_debounced, pb_press, pb_release, pb_long} !== e) begin
                    errors++;
                    $display("FAIL outputs cyc %0d: deb/press/rel/long got %b %b %b %b want %b %b %b %b",
                             cyc, pb_debounced, pb_press, pb_release, pb_long,
                             e[15:12], e[11:8], e[7:4], e[3:0]);
                end
            end
        end
    end

    initial begin : stim
        logic [N-1:0] lvl;
        int           rem [N];
        m_t = 0; m_p1 = '0; m_p2 = '0; m_deb = '0;
        pb_in = '0;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) step('0, 1'b0);

        for (int i = 0; i < 12; i++) step(4'b0001, 1'b1);
        for (int i = 0; i < 10; i++) step(4'b0000, 1'b1);

        for (int i = 0; i < 3; i++)  step(4'b0010, 1'b1);
        for (int i = 0; i < 10; i++) step(4'b0000, 1'b1);

        step(4'b0100, 1'b1); step(4'b0000, 1'b1);
        for (int i = 0; i < 12; i++) step(4'b0100, 1'b1);
        for (int i = 0; i < 10; i++) step(4'b0000, 1'b1);

        for (int i = 0; i < 26; i++) step(4'b1000, 1'b1);
        for (int i = 0; i < 12; i++) step(4'b0000, 1'b1);

        for (int i = 0; i < 4; i++) step(4'b1111, 1'b1);
        step(4'b1111, 1'b0);
        checks++;
        if ({pb_debounced, pb_press, pb_release, pb_long} !== '0) begin
            errors++;
            $display("FAIL async_reset: got %h want 0", {pb_debounced, pb_press, pb_release, pb_long});
        end
        step(4'b1111, 1'b0);
        for (int i = 0; i < 14; i++) step(4'b1111, 1'b1);
        for (int i = 0; i < 10; i++) step(4'b0000, 1'b1);

        lvl = '0;
        for (int c = 0; c < N; c++) rem[c] = 1;
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < N; c++) begin
                rem[c]--;
                if (rem[c] <= 0) begin
                    lvl[c] = ~lvl[c];
                    rem[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(11, 25))
                                                         : int'($urandom_range(1, 6));
                end
            end
            step(lvl, ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1);
        end

        for (int i = 0; i < 4; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
